gb_timer: RTL and testbench
===========================

# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer. Sits directly upstream of `mem_unit`: it snoops Z80 bus writes to FF04–FF07 and drives the `DIV`, `TIMA`, `TMA` and `TAC` values that `mem_unit` returns on reads. On TIMA overflow it raises a one-cycle `timer_irq` to the interrupt-flag logic, which sets IF bit 2. One `clk` edge is one T-cycle (4.194304 MHz nominal).

## Interface
- `RELOAD_DELAY`, default 4: clocks from TIMA overflow to TMA reload and IRQ; legal range 1–15.
- `clk`  in  1  system clock; single clock domain.
- `Reset_n`  in  1  synchronous, active-low reset.
- `z80_mreq_n`  in  1  Z80 memory request, active low.
- `z80_write_n`  in  1  Z80 write, active low.
- `z80_address`  in  16  Z80 address bus.
- `z80_dout`  in  8  Z80 write data.
- `DIV`  out  8  divider register; equals `sys_cnt[15:8]`.
- `TIMA`  out  8  timer counter.
- `TMA`  out  8  timer modulo.
- `TAC`  out  8  `{5'b11111, tac[2:0]}`.
- `timer_irq`  out  1  one-clock pulse; drives the IF bit 2 set input.

## Operation
- **Write strobe**
  - `wr = ~z80_mreq_n & ~z80_write_n`; `wr_q` is `wr` registered.
  - `wstb = wr & ~wr_q`, so each bus write acts exactly once. Address and data are sampled in the `wstb` cycle.
- **System counter** `sys_cnt[15:0]`
  - Increments by 1 every clk and wraps FFFF→0000.
  - `wstb` to FF04 (any data) forces `sys_cnt` to 0000 on that edge instead of incrementing.
- **Tap select** (`tac[1:0]`): 00→`sys_cnt[9]`, 01→bit 3, 10→bit 5, 11→bit 7.
- **Increment event**
  - `tap = tac[2] & sys_cnt[sel]`; `tap_q` is `tap` registered.
  - `inc = tap_q & ~tap`.
  - A DIV reset or a TAC write that drops `tap` from 1 to 0 therefore also produces `inc`. This glitch is intentional and matches DMG behaviour.
- **TIMA FSM**, states RUN and OVF (`dly` is a 4-bit down-counter):
  - RUN, `inc`, TIMA≠FF: TIMA+1.
  - RUN, `inc`, TIMA=FF: TIMA←00, `dly`←RELOAD_DELAY−1, go to OVF.
  - OVF, `dly`≠0: `dly`−1. An `inc` in this state applies to TIMA normally.
  - OVF, `dly`=0: TIMA←TMA (the value after any same-edge TMA write), `timer_irq`←1, go to RUN.
  - `wstb` to FF05 while in OVF with `dly`≠0: TIMA←data, reload and IRQ cancelled, go to RUN.
  - `wstb` to FF05 on the reload edge (`dly`=0): ignored; the reload wins.
- **Register writes**
  - FF05 in RUN: the written value wins over a same-edge `inc`.
  - FF06 writes TMA.
  - FF07 writes `tac[2:0]`; `z80_dout[7:3]` are ignored.
- **Non-writes**: `mem_unit` owns all reads. This block ignores reads and all other addresses.

## Timing
- **Reset** (`Reset_n`=0 at a clk edge) clears: `sys_cnt`=0000, DIV=00, TIMA=00, TMA=00, TAC=F8, `timer_irq`=0, `wr_q`=0, `tap_q`=0, state=RUN. Reset mid-OVF abandons the reload and IRQ.
- **DIV** steps every 256 clocks; the first step is 256 clocks after reset release.
- **TIMA latency**: TIMA changes on the edge after the one where `tap` falls. With TAC=05 from reset, the first TIMA increment lands 17 clocks after release, then every 16 clocks.
- **Overflow timing**: the edge where TIMA becomes 00 is E0. TIMA=TMA and `timer_irq`=1 from edge E0+RELOAD_DELAY. `timer_irq` returns to 0 at E0+RELOAD_DELAY+1.
- **Register writes** take effect on the `wstb` edge and are visible on the outputs the following cycle.
- **All outputs are registered**; nothing is combinational from the bus.

## Structure
- Shared package `gb_pkg`:
  - Address constants `ADDR_DIV`=16'hFF04, `ADDR_TIMA`=16'hFF05, `ADDR_TMA`=16'hFF06, `ADDR_TAC`=16'hFF07, `ADDR_IF`=16'hFF0F.
  - Enum `timer_state_t` {RUN, OVF}.
  - TAC tap-index constants {9, 3, 5, 7}.
- Single module with no sub-module. The write-strobe detector is small enough to stay inline.

## Test plan
- **DIV count and reset**: release reset, TAC=00 → DIV=01 at clock 256 and TIMA stays 00. Write FF04 at clock 300 → DIV=00 next cycle, then 01 at 256 clocks after the write.
- **TIMA rate**: write TAC=05 → TIMA increments every 16 clocks. Write TAC=04 → every 1024 clocks. Hold `z80_write_n` low for 5 clocks on a TIMA write of 10 → exactly one write occurs and TIMA=10 the next cycle.
- **Overflow and reload**: TMA=AB, TIMA=FF, TAC=05 → TIMA=00 for 4 clocks, then AB with `timer_irq` high for exactly 1 clock.
- **Cancel**: TIMA write of 33 two clocks after overflow → TIMA=33, no IRQ, no reload. TIMA write on the reload edge → TIMA=TMA and the IRQ still fires.
- **Glitch increments**: TAC=05 with `sys_cnt[3]`=1, then write DIV → TIMA+1 one cycle later. Write TAC=01 with the tap high → TIMA+1.
- **Reset mid-OVF**: assert `Reset_n`=0 for one clock during OVF → all outputs at their reset values, TAC reads F8, and no IRQ afterwards.

Source files
------------

// File: rtl/gb_pkg.sv
// gb_pkg: shared Game Boy I/O address map, timer FSM states and TAC tap selection
package gb_pkg;
    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;
    localparam logic [15:0] ADDR_IF   = 16'hFF0F;
    typedef enum logic {RUN, OVF} timer_state_t;
    localparam logic [3:0] TAP_IDX_00 = 4'd9;
    localparam logic [3:0] TAP_IDX_01 = 4'd3;
    localparam logic [3:0] TAP_IDX_10 = 4'd5;
    localparam logic [3:0] TAP_IDX_11 = 4'd7;
    function automatic logic [3:0] tap_idx(input logic [1:0] sel);
        return sel == 2'd0 ? TAP_IDX_00 : sel == 2'd1 ? TAP_IDX_01 : sel == 2'd2 ? TAP_IDX_10 : TAP_IDX_11;
    endfunction
endpackage

// File: rtl/gb_timer.sv
// gb_timer: DMG DIV/TIMA/TMA/TAC timer snooping Z80 writes to FF04-FF07.
// Ports: clk, Reset_n (sync, active low); z80_mreq_n/z80_write_n/z80_address/z80_dout
// bus snoop inputs; DIV/TIMA/TMA/TAC register values for read-back; timer_irq
// one-clock pulse on TIMA reload. RELOAD_DELAY (1-15) clocks from overflow to reload.
module gb_timer
    import gb_pkg::*;
#(
    parameter int unsigned RELOAD_DELAY = 4
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        z80_mreq_n,
    input  logic        z80_write_n,
    input  logic [15:0] z80_address,
    input  logic [7:0]  z80_dout,
    output logic [7:0]  DIV,
    output logic [7:0]  TIMA,
    output logic [7:0]  TMA,
    output logic [7:0]  TAC,
    output logic        timer_irq
);
    localparam logic [3:0] RELOAD_DLY = 4'(RELOAD_DELAY - 1);
    timer_state_t r_state, w_state_n;
    logic [15:0] r_sys_cnt;
    logic [7:0]  r_tima, r_tma, w_tima_n, w_tma_n;
    logic [3:0]  r_dly, w_dly_n;
    logic [2:0]  r_tac;
    logic        r_wr_q, r_tap_q, r_irq, w_irq_n;
    logic        w_wr, w_wstb, w_tap, w_inc;
    logic        w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
    assign w_wr      = ~z80_mreq_n & ~z80_write_n;
    assign w_wstb    = w_wr & ~r_wr_q;
    assign w_wr_div  = w_wstb & (z80_address == ADDR_DIV);
    assign w_wr_tima = w_wstb & (z80_address == ADDR_TIMA);
    assign w_wr_tma  = w_wstb & (z80_address == ADDR_TMA);
    assign w_wr_tac  = w_wstb & (z80_address == ADDR_TAC);
    // Falling edge of the selected divider bit; a DIV clear or TAC change that
    // drops the tap also counts, as on real hardware.
    assign w_tap     = r_tac[2] & r_sys_cnt[tap_idx(r_tac[1:0])];
    assign w_inc     = r_tap_q & ~w_tap;
    // Reload picks up a TMA write landing on the same edge.
    assign w_tma_n   = w_wr_tma ? z80_dout : r_tma;
    always_comb begin
        w_state_n = r_state;
        w_tima_n  = r_tima;
        w_dly_n   = r_dly;
        w_irq_n   = 1'b0;
        if (r_state == RUN) begin
            if (w_wr_tima) begin
                w_tima_n = z80_dout;
            end else if (w_inc && r_tima == 8'hFF) begin
                w_tima_n  = 8'h00;
                w_dly_n   = RELOAD_DLY;
                w_state_n = OVF;
            end else if (w_inc) begin
                w_tima_n = r_tima + 8'd1;
            end
        end else if (r_dly == 4'd0) begin
            w_tima_n  = w_tma_n;
            w_irq_n   = 1'b1;
            w_state_n = RUN;
        end else if (w_wr_tima) begin
            w_tima_n  = z80_dout;
            w_state_n = RUN;
        end else begin
            w_dly_n  = r_dly - 4'd1;
            w_tima_n = w_inc ? r_tima + 8'd1 : r_tima;
        end
    end
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_state   <= RUN;
            r_sys_cnt <= '0;
            r_tima    <= '0;
            r_tma     <= '0;
            r_tac     <= '0;
            r_dly     <= '0;
            r_wr_q    <= 1'b0;
            r_tap_q   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_sys_cnt <= w_wr_div ? 16'h0000 : r_sys_cnt + 16'd1;
            r_tima    <= w_tima_n;
            r_tma     <= w_tma_n;
            r_tac     <= w_wr_tac ? z80_dout[2:0] : r_tac;
            r_dly     <= w_dly_n;
            r_wr_q    <= w_wr;
            r_tap_q   <= w_tap;
            r_irq     <= w_irq_n;
        end
    end
    assign DIV       = r_sys_cnt[15:8];
    assign TIMA      = r_tima;
    assign TMA       = r_tma;
    assign TAC       = {5'b11111, r_tac};
    assign timer_irq = r_irq;
endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed self-checking bench for gb_timer
module tb_gb_timer;
    import gb_pkg::*;
    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        z80_mreq_n = 1'b1;
    logic        z80_write_n = 1'b1;
    logic [15:0] z80_address = '0;
    logic [7:0]  z80_dout = '0;
    logic [7:0]  DIV, TIMA, TMA, TAC;
    logic        timer_irq;
    int          vectors = 0;
    int          miscompares = 0;
    always #5 clk = ~clk;
    gb_timer dut (
        .clk(clk),
        .Reset_n(Reset_n),
        .z80_mreq_n(z80_mreq_n),
        .z80_write_n(z80_write_n),
        .z80_address(z80_address),
        .z80_dout(z80_dout),
        .DIV(DIV),
        .TIMA(TIMA),
        .TMA(TMA),
        .TAC(TAC),
        .timer_irq(timer_irq)
    );
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
    endtask
    task automatic wr1(input logic [15:0] a, input logic [7:0] d);
        z80_mreq_n  = 1'b0;
        z80_write_n = 1'b0;
        z80_address = a;
        z80_dout    = d;
        tick(1);
        z80_mreq_n  = 1'b1;
        z80_write_n = 1'b1;
    endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        wr1(a, d);
        tick(1);
    endtask
    // TMA=AB, TIMA=FF, TAC=F5; returns after edge 6, overflow lands on edge 17
    task automatic ovf_setup();
        do_reset();
        wr(ADDR_TMA, 8'hAB);
        wr(ADDR_TIMA, 8'hFF);
        wr(ADDR_TAC, 8'hF5);
    endtask
    task automatic test_reset();
        do_reset();
        vectors++; if (DIV !== 8'h00) begin miscompares++; $display("FAIL reset_div got %h exp 00", DIV); end
        vectors++; if (TIMA !== 8'h00) begin miscompares++; $display("FAIL reset_tima got %h exp 00", TIMA); end
        vectors++; if (TMA !== 8'h00) begin miscompares++; $display("FAIL reset_tma got %h exp 00", TMA); end
        vectors++; if (TAC !== 8'hF8) begin miscompares++; $display("FAIL reset_tac got %h exp F8", TAC); end
        vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", timer_irq); end
    endtask
    task automatic test_div();
        do_reset();
        tick(255);
        vectors++; if (DIV !== 8'h00) begin miscompares++; $display("FAIL div_255 got %h exp 00", DIV); end
        tick(1);
        vectors++; if (DIV !== 8'h01) begin miscompares++; $display("FAIL div_256 got %h exp 01", DIV); end
        vectors++; if (TIMA !== 8'h00) begin miscompares++; $display("FAIL div_tima_idle got %h exp 00", TIMA); end
        tick(43);
        wr1(ADDR_DIV, 8'h5A);
        vectors++; if (DIV !== 8'h00) begin miscompares++; $display("FAIL div_clear got %h exp 00", DIV); end
        tick(255);
        vectors++; if (DIV !== 8'h00) begin miscompares++; $display("FAIL div_clear_255 got %h exp 00", DIV); end
        tick(1);
        vectors++; if (DIV !== 8'h01) begin miscompares++; $display("FAIL div_clear_256 got %h exp 01", DIV); end
    endtask
    task automatic test_tima_rate();
        do_reset();
        wr(ADDR_TAC, 8'h05);
        vectors++; if (TAC !== 8'hFD) begin miscompares++; $display("FAIL rate_tac05 got %h exp FD", TAC); end
        tick(14);
        vectors++; if (TIMA !== 8'h00) begin miscompares++; $display("FAIL rate16_e16 got %h exp 00", TIMA); end
        tick(1);
        vectors++; if (TIMA !== 8'h01) begin miscompares++; $display("FAIL rate16_e17 got %h exp 01", TIMA); end
        tick(15);
        vectors++; if (TIMA !== 8'h01) begin miscompares++; $display("FAIL rate16_e32 got %h exp 01", TIMA); end
        tick(1);
        vectors++; if (TIMA !== 8'h02) begin miscompares++; $display("FAIL rate16_e33 got %h exp 02", TIMA); end
        wr(ADDR_TAC, 8'h04);
        vectors++; if (TAC !== 8'hFC) begin miscompares++; $display("FAIL rate_tac04 got %h exp FC", TAC); end
        tick(989);
        vectors++; if (TIMA !== 8'h02) begin miscompares++; $display("FAIL rate1024_e1024 got %h exp 02", TIMA); end
        tick(1);
        vectors++; if (TIMA !== 8'h03) begin miscompares++; $display("FAIL rate1024_e1025 got %h exp 03", TIMA); end
        tick(1023);
        vectors++; if (TIMA !== 8'h03) begin miscompares++; $display("FAIL rate1024_e2048 got %h exp 03", TIMA); end
        tick(1);
        vectors++; if (TIMA !== 8'h04) begin miscompares++; $display("FAIL rate1024_e2049 got %h exp 04", TIMA); end
        z80_mreq_n  = 1'b0;
        z80_write_n = 1'b0;
        z80_address = ADDR_TIMA;
        z80_dout    = 8'h10;
        tick(1);
        vectors++; if (TIMA !== 8'h10) begin miscompares++; $display("FAIL hold_first got %h exp 10", TIMA); end
        z80_dout = 8'h77;
        tick(4);
        z80_mreq_n  = 1'b1;
        z80_write_n = 1'b1;
        tick(1);
        vectors++; if (TIMA !== 8'h10) begin miscompares++; $display("FAIL hold_once got %h exp 10", TIMA); end
    endtask
    task automatic test_overflow();
        ovf_setup();
        vectors++; if (TAC !== 8'hFD) begin miscompares++; $display("FAIL ovf_tac_upper got %h exp FD", TAC); end
        vectors++; if (TMA !== 8'hAB) begin miscompares++; $display("FAIL ovf_tma got %h exp AB", TMA); end
        vectors++; if (TIMA !== 8'hFF) begin miscompares++; $display("FAIL ovf_tima_ff got %h exp FF", TIMA); end
        tick(11);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (TIMA !== 8'h00) begin miscompares++; $display("FAIL ovf_zero_%0d got %h exp 00", i, TIMA); end
            vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL ovf_noirq_%0d got %b exp 0", i, timer_irq); end
            tick(1);
        end
        vectors++; if (TIMA !== 8'hAB) begin miscompares++; $display("FAIL ovf_reload got %h exp AB", TIMA); end
        vectors++; if (timer_irq !== 1'b1) begin miscompares++; $display("FAIL ovf_irq got %b exp 1", timer_irq); end
        tick(1);
        vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL ovf_irq_end got %b exp 0", timer_irq); end
        vectors++; if (TIMA !== 8'hAB) begin miscompares++; $display("FAIL ovf_hold got %h exp AB", TIMA); end
    endtask
    task automatic test_cancel();
        ovf_setup();
        tick(12);
        wr1(ADDR_TIMA, 8'h33);
        vectors++; if (TIMA !== 8'h33) begin miscompares++; $display("FAIL cancel_tima got %h exp 33", TIMA); end
        for (int i = 0; i < 8; i++) begin
            tick(1);
            vectors++; if (timer_irq !== 1'b0 || TIMA !== 8'h33) begin miscompares++; $display("FAIL cancel_quiet_%0d got irq=%b tima=%h exp irq=0 tima=33", i, timer_irq, TIMA); end
        end
        ovf_setup();
        tick(14);
        wr1(ADDR_TIMA, 8'h55);
        vectors++; if (TIMA !== 8'hAB) begin miscompares++; $display("FAIL reload_wins_tima got %h exp AB", TIMA); end
        vectors++; if (timer_irq !== 1'b1) begin miscompares++; $display("FAIL reload_wins_irq got %b exp 1", timer_irq); end
        tick(1);
        vectors++; if (timer_irq !== 1'b0 || TIMA !== 8'hAB) begin miscompares++; $display("FAIL reload_wins_after got irq=%b tima=%h exp irq=0 tima=AB", timer_irq, TIMA); end
    endtask
    task automatic test_glitch();
        do_reset();
        wr(ADDR_TAC, 8'h05);
        tick(8);
        wr1(ADDR_DIV, 8'h00);
        vectors++; if (TIMA !== 8'h00 || DIV !== 8'h00) begin miscompares++; $display("FAIL glitch_div_edge got tima=%h div=%h exp 00/00", TIMA, DIV); end
        tick(1);
        vectors++; if (TIMA !== 8'h01) begin miscompares++; $display("FAIL glitch_div_inc got %h exp 01", TIMA); end
        tick(8);
        wr1(ADDR_TAC, 8'h01);
        vectors++; if (TIMA !== 8'h01) begin miscompares++; $display("FAIL glitch_tac_edge got %h exp 01", TIMA); end
        tick(1);
        vectors++; if (TIMA !== 8'h02) begin miscompares++; $display("FAIL glitch_tac_inc got %h exp 02", TIMA); end
        tick(40);
        vectors++; if (TIMA !== 8'h02) begin miscompares++; $display("FAIL glitch_tac_stopped got %h exp 02", TIMA); end
    endtask
    task automatic test_reset_mid_ovf();
        ovf_setup();
        tick(12);
        Reset_n = 1'b0;
        tick(1);
        Reset_n = 1'b1;
        vectors++; if (DIV !== 8'h00 || TIMA !== 8'h00 || TMA !== 8'h00) begin miscompares++; $display("FAIL midovf_regs got div=%h tima=%h tma=%h exp 00/00/00", DIV, TIMA, TMA); end
        vectors++; if (TAC !== 8'hF8) begin miscompares++; $display("FAIL midovf_tac got %h exp F8", TAC); end
        vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL midovf_irq got %b exp 0", timer_irq); end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            vectors++; if (timer_irq !== 1'b0 || TIMA !== 8'h00) begin miscompares++; $display("FAIL midovf_after_%0d got irq=%b tima=%h exp irq=0 tima=00", i, timer_irq, TIMA); end
        end
    endtask
    initial begin
        test_reset();
        test_div();
        test_tima_rate();
        test_overflow();
        test_cancel();
        test_glitch();
        test_reset_mid_ovf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
